// File: rtl/pdma_pkg.sv
// Shared types and default sizing for the PDMA FIFO arbiter.
package pdma_pkg;

    // Arbiter FSM: idle, or one requester owns the FIFO write port for a whole frame.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGnt0 = 2'd1,
        StGnt1 = 2'd2
    } pdma_state_e;

    typedef logic [15:0] pdma_word_t;

    localparam int unsigned DefDepthWords = 100;
    localparam int unsigned DefFrameMax   = 16;
    localparam int unsigned DefDmaBurst   = 64;

endpackage

// File: rtl/pdma_dma_req.sv
// DMA drain request: raised once enough bytes are readable, held until acknowledged.
module pdma_dma_req
    import pdma_pkg::*;
#(
    parameter int unsigned DMA_BURST = DefDmaBurst
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [8:0] fifo_rdcnt_i,
    input  logic       dma_ack_i,
    output logic       dma_req_o
);

    logic req_q;
    logic req_d;
    logic burst_ready;

    assign burst_ready = 32'(fifo_rdcnt_i) >= DMA_BURST;

    // Next request state; an ack seen while no request is pending is ignored.
    always_comb begin
        req_d = req_q;
        if (req_q) begin
            if (dma_ack_i) begin
                req_d = 1'b0;
            end
        end else if (burst_ready) begin
            req_d = 1'b1;
        end
    end

    // Request register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_q <= 1'b0;
        end else begin
            req_q <= req_d;
        end
    end

    assign dma_req_o = req_q;

endmodule

// File: rtl/pdma_fifo_arbiter.sv
// Two-requester frame-atomic arbiter in front of a write FIFO, plus DMA drain request.
// Optional feature macro PDMA_ARB_DROP_EN: S0 frames that find no space are swallowed
// and counted on drop_cnt_o instead of being back-pressured.
module pdma_fifo_arbiter
    import pdma_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DefDepthWords,
    parameter int unsigned FRAME_MAX   = DefFrameMax,
    parameter int unsigned DMA_BURST   = DefDmaBurst
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       s0_valid_i,
    input  logic       s0_last_i,
    input  pdma_word_t s0_data_i,
    output logic       s0_ready_o,
    input  logic       s1_valid_i,
    input  logic       s1_last_i,
    input  pdma_word_t s1_data_i,
    output logic       s1_ready_o,
    output logic       fifo_we_o,
    output pdma_word_t fifo_data_o,
    input  logic       fifo_full_i,
    input  logic       fifo_overflow_i,
    input  logic [7:0] fifo_wrcnt_i,
    input  logic [8:0] fifo_rdcnt_i,
    output logic       dma_req_o,
    input  logic       dma_ack_i,
    output logic       err_o,
    output logic [7:0] drop_cnt_o
);

    localparam int unsigned BeatW = $clog2(FRAME_MAX + 1);

    pdma_state_e      state_q;
    logic             prio_s1_q;   // S1 wins the next tie after an S0 frame
    logic [BeatW-1:0] beat_q;      // beats written in the current frame, stops at FRAME_MAX
    logic             fifo_we_q;
    pdma_word_t       fifo_data_q;
    logic             err_q;

    logic       space_ok;
    logic       acc0;
    logic       acc1;
    logic       acc;
    logic       acc_last;
    pdma_word_t acc_data;
    logic       beat_over;
    logic       discard;

    // Room for a worst-case frame must exist before any grant.
    assign space_ok = (32'(fifo_wrcnt_i) + FRAME_MAX) <= DEPTH_WORDS;

`ifdef PDMA_ARB_DROP_EN
    logic       drop_q;
    logic [7:0] drop_cnt_q;

    // A dropping S0 frame is drained regardless of FIFO fullness.
    assign s0_ready_o = (state_q == StGnt0) & (drop_q | ~fifo_full_i);
    assign discard    = drop_q;
    assign drop_cnt_o = drop_cnt_q;
`else
    assign s0_ready_o = (state_q == StGnt0) & ~fifo_full_i;
    assign discard    = 1'b0;
    assign drop_cnt_o = 8'd0;
`endif
    assign s1_ready_o = (state_q == StGnt1) & ~fifo_full_i;

    assign acc0      = s0_valid_i & s0_ready_o;
    assign acc1      = s1_valid_i & s1_ready_o;
    assign acc       = acc0 | acc1;
    assign acc_last  = acc0 ? s0_last_i : s1_last_i;
    assign acc_data  = acc0 ? s0_data_i : s1_data_i;
    assign beat_over = beat_q == BeatW'(FRAME_MAX);

    // Arbitration FSM with registered FIFO write port and sticky error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            prio_s1_q   <= 1'b0;
            beat_q      <= '0;
            fifo_we_q   <= 1'b0;
            fifo_data_q <= '0;
            err_q       <= 1'b0;
`ifdef PDMA_ARB_DROP_EN
            drop_q      <= 1'b0;
            drop_cnt_q  <= 8'd0;
`endif
        end else begin
            fifo_we_q <= 1'b0;
            if (fifo_overflow_i) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (space_ok && s0_valid_i && (!s1_valid_i || !prio_s1_q)) begin
                        state_q <= StGnt0;
                    end else if (space_ok && s1_valid_i) begin
                        state_q <= StGnt1;
`ifdef PDMA_ARB_DROP_EN
                    end else if (s0_valid_i) begin
                        state_q <= StGnt0;
                        drop_q  <= 1'b1;
`endif
                    end
                end
                StGnt0, StGnt1: begin
                    if (acc) begin
                        if (!discard) begin
                            // Oversized frames: extra beats are consumed but never written.
                            if (beat_over) begin
                                err_q <= 1'b1;
                            end else begin
                                beat_q      <= beat_q + BeatW'(1);
                                fifo_we_q   <= 1'b1;
                                fifo_data_q <= acc_data;
                            end
                        end
                        if (acc_last) begin
                            state_q   <= StIdle;
                            beat_q    <= '0;
                            prio_s1_q <= (state_q == StGnt0);
`ifdef PDMA_ARB_DROP_EN
                            if (drop_q) begin
                                drop_q <= 1'b0;
                                if (drop_cnt_q != 8'hff) begin
                                    drop_cnt_q <= drop_cnt_q + 8'd1;
                                end
                            end
`endif
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign fifo_we_o   = fifo_we_q;
    assign fifo_data_o = fifo_data_q;
    assign err_o       = err_q;

    pdma_dma_req #(
        .DMA_BURST (DMA_BURST)
    ) u_dma_req (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .fifo_rdcnt_i (fifo_rdcnt_i),
        .dma_ack_i    (dma_ack_i),
        .dma_req_o    (dma_req_o)
    );

endmodule

// File: doc/pdma_fifo_arbiter.md
PDMA_FIFO_ARBITER -- requirements
Module: pdma_fifo_arbiter

Interface
REQ-001 Parameter DEPTH_WORDS, default 100: FIFO write-side depth in 16-bit words.
REQ-002 Parameter FRAME_MAX, default 16: maximum words per requester frame; space reserved per grant.
REQ-003 Parameter DMA_BURST, default 64: read-side byte count that raises a DMA request.
REQ-004 CLK  in  1  sole clock; all state changes on rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 S0_VALID / S0_LAST  in  1 each  EMG sample requester (high priority): beat valid, last beat of frame.
REQ-007 S0_DATA  in  16  requester-0 word; S0_READY  out  1  beat accepted when S0_VALID & S0_READY.
REQ-008 S1_VALID, S1_LAST, S1_DATA[15:0] in and S1_READY out: status/response requester (low priority), same semantics.
REQ-009 FIFO_WE  out  1  active-high write strobe; FIFO_DATA  out  16  write word.
REQ-010 FIFO_FULL, FIFO_OVERFLOW  in  1 each; FIFO_WRCNT  in  8  words stored; FIFO_RDCNT  in  9  bytes readable.
REQ-011 DMA_REQ  out  1  drain request; DMA_ACK  in  1  single-cycle burst-accepted pulse.
REQ-012 ERR  out  1  sticky overflow flag; DROP_CNT  out  8  dropped-frame counter.

Function
REQ-013 FSM states IDLE, GNT0, GNT1; exactly one requester is granted at a time.
REQ-014 IDLE->GNT0 when S0_VALID and (DEPTH_WORDS - FIFO_WRCNT) >= FRAME_MAX; else IDLE->GNT1 under the same space condition with S1_VALID.
REQ-015 Grants are frame-atomic: GNTx->IDLE on the cycle the beat with Sx_LAST is accepted; no preemption mid-frame.
REQ-016 After a GNT1 frame completes, S0 wins the next arbitration whenever both are valid; after GNT0, S1 wins if valid (alternating when both pend).
REQ-017 Sx_READY = (state == GNTx) & ~FIFO_FULL; combinational from state and FIFO_FULL only.
REQ-018 FIFO_WE and FIFO_DATA are registered: an accepted beat appears on FIFO_WE/FIFO_DATA exactly 1 cycle after acceptance; FIFO_WE is high for one cycle per beat.
REQ-019 A frame exceeding FRAME_MAX beats is truncated: beats beyond FRAME_MAX are accepted but not written, ERR is set, and the grant ends at Sx_LAST.
REQ-020 DMA_REQ rises the cycle after FIFO_RDCNT >= DMA_BURST while DMA_REQ is low; it holds until DMA_ACK, clears on the cycle after DMA_ACK, and re-arms next evaluation.
REQ-021 DMA_ACK while DMA_REQ is low is ignored.
REQ-022 ERR sets on any cycle FIFO_OVERFLOW is high and stays set until RESET.
REQ-023 DROP_CNT saturates at 255.

Reset
REQ-024 RESET forces state IDLE, S0_READY=S1_READY=0, FIFO_WE=0, FIFO_DATA=0, DMA_REQ=0, ERR=0, DROP_CNT=0 on the next edge.
REQ-025 RESET mid-frame abandons the frame; the pending registered write is not issued.

Configuration
REQ-026 Macro PDMA_ARB_DROP_EN: when defined, an S0 frame that cannot obtain space in IDLE enters GNT0 in drop mode (S0_READY=1, no FIFO_WE) until S0_LAST, then DROP_CNT increments.
REQ-027 Without PDMA_ARB_DROP_EN, S0 is back-pressured (S0_READY=0) until space is available, and DROP_CNT is tied to 0.

Structure
REQ-028 Shared package pdma_pkg holds the FSM state enumeration, the 16-bit word type, and the default DEPTH_WORDS/FRAME_MAX/DMA_BURST constants.
REQ-029 Sub-module pdma_dma_req holds the DMA request/ack handshake (REQ-020/021); arbitration stays in the top level.

Verification
REQ-030 Both requesters valid, FIFO_WRCNT=0, 4-beat frames -> S0 frame written first, then S1, then S0; FIFO_WE count 12 for 3 frames, each write 1 cycle after acceptance.
REQ-031 FIFO_WRCNT=90, S0_VALID -> no grant (space 10 < 16); without macro S0_READY stays 0; with macro 4 beats consumed, DROP_CNT=1, no FIFO_WE.
REQ-032 FIFO_RDCNT steps 63->64 -> DMA_REQ high next cycle; DMA_ACK pulse -> DMA_REQ low next cycle; RDCNT still 64 -> DMA_REQ reasserts.
REQ-033 FIFO_FULL pulsed mid-frame at beat 2 -> S0_READY low that cycle, frame resumes, all beats written once in order.
REQ-034 RESET asserted at beat 3 of a 6-beat frame -> all outputs at reset values next edge, state IDLE, no further FIFO_WE; FIFO_OVERFLOW pulse afterward -> ERR=1 held.
